// File: rtl/instruction_assembly_fifo_pkg.sv
// Shared types and constants for the instruction assembly FIFO.
package instruction_assembly_fifo_pkg;

  localparam int BYTE_WIDTH = 8;
  localparam int INSTR_BITS = 10 * BYTE_WIDTH;
  localparam int SEG_BITS   = 4 * BYTE_WIDTH;

  // Integer ceiling division, used to size the segment count.
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  localparam int INSTR_SEG_COUNT = ceil_div(INSTR_BITS, SEG_BITS);

  typedef logic [SEG_BITS-1:0]   segment_t;
  typedef logic [INSTR_BITS-1:0] instruction_t;

  // Bit positions inside the sticky error vector.
  localparam int ERR_OVERFLOW = 0;
  localparam int ERR_BAD_SEL  = 1;

endpackage

// File: rtl/instruction_assembly_fifo_stager.sv
// Staging register: collects host segments until a whole instruction is present.
module instruction_stager
  import instruction_assembly_fifo_pkg::*;
#(
  parameter int  INSTR_WIDTH = INSTR_BITS,
  parameter int  SEG_WIDTH   = SEG_BITS,
  localparam int NUM_SEGS    = ceil_div(INSTR_WIDTH, SEG_WIDTH),
  localparam int SEL_W       = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1,
  localparam int TOP_W       = INSTR_WIDTH - (NUM_SEGS - 1) * SEG_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   wr_en_i,
  input  logic [SEL_W-1:0]       sel_i,
  input  logic [SEG_WIDTH-1:0]   data_i,
  output logic                   complete_o,
  output logic [INSTR_WIDTH-1:0] instr_o
);

  logic [NUM_SEGS-1:0] valid_q;
  logic [NUM_SEGS-1:0] valid_d;

  for (genvar gi = 0; gi < NUM_SEGS; gi++) begin : g_slot
    // The top slot only stores the bits that fit inside the instruction.
    localparam int W = (gi == NUM_SEGS - 1) ? TOP_W : SEG_WIDTH;
    logic [W-1:0] slot_q;
    logic         hit;

    assign hit = wr_en_i && (32'(sel_i) == gi);
    // A push clears the slot first; a same-cycle write then re-arms it for the next instruction.
    assign valid_d[gi] = !flush_i && ((valid_q[gi] && !push_i) || hit);
    assign instr_o[gi*SEG_WIDTH +: W] = slot_q;

    // Slot payload: last accepted write wins.
    always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
        slot_q <= '0;
      end else if (hit) begin
        slot_q <= data_i[W-1:0];
      end
    end
  end

  assign complete_o = &valid_q;

  // Per-slot valid bits.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/instruction_assembly_fifo.sv
// Circular instruction buffer fed by the stager, FWFT read with valid/ready.
module instruction_assembly_fifo
  import instruction_assembly_fifo_pkg::*;
#(
  parameter int  INSTR_WIDTH       = INSTR_BITS,
  parameter int  SEG_WIDTH         = SEG_BITS,
  parameter int  FIFO_DEPTH        = 32,
  parameter int  ALMOST_FULL_LEVEL = FIFO_DEPTH - 2,
  localparam int NUM_SEGS          = ceil_div(INSTR_WIDTH, SEG_WIDTH),
  localparam int SEL_W             = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1,
  localparam int PTR_W             = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SEG_WIDTH-1:0]   seg_data,
  input  logic [SEL_W-1:0]       seg_sel,
  input  logic                   seg_we,
  output logic                   seg_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   flush,
  input  logic                   clear_err,
  output logic [PTR_W-1:0]       count,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_full,
  output logic [1:0]             err
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] count_q, count_d;
  logic [1:0]       err_q, err_d;

  logic [INSTR_WIDTH-1:0] mem [FIFO_DEPTH];

  logic                   complete;
  logic [INSTR_WIDTH-1:0] staged_instr;
  logic                   pop, push, sel_ok, seg_accept;
  logic                   push_eff;

  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]) &&
                       (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]);
  assign almost_full = (32'(count_q) >= ALMOST_FULL_LEVEL);
  assign out_valid   = !empty;
  assign count       = count_q;
  assign err         = err_q;

  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign pop        = out_valid && out_ready;
  assign push       = complete && (!full || pop);
  assign seg_ready  = !(complete && full && !pop);
  assign sel_ok     = (32'(seg_sel) < NUM_SEGS);
  assign seg_accept = seg_we && seg_ready && sel_ok && !flush;
  assign push_eff   = push && !flush;

  assign out_instr = empty ? '0 : mem[rd_ptr_q[PTR_W-2:0]];

  instruction_stager #(
    .INSTR_WIDTH (INSTR_WIDTH),
    .SEG_WIDTH   (SEG_WIDTH)
  ) u_stager (
    .clk        (clk),
    .rst_ni     (rst),
    .flush_i    (flush),
    .push_i     (push_eff),
    .wr_en_i    (seg_accept),
    .sel_i      (seg_sel),
    .data_i     (seg_data),
    .complete_o (complete),
    .instr_o    (staged_instr)
  );

  // Next-state for pointers, occupancy and sticky errors; flush overrides traffic but not err.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = clear_err ? 2'b00 : err_q;
    if (seg_we && !seg_ready) err_d[ERR_OVERFLOW] = 1'b1;
    if (seg_we && !sel_ok)    err_d[ERR_BAD_SEL]  = 1'b1;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Buffer storage; contents are never reset.
  always_ff @(posedge clk) begin
    if (push_eff) begin
      mem[wr_ptr_q[PTR_W-2:0]] <= staged_instr;
    end
  end

endmodule

// File: tb/tb_instruction_assembly_fifo.sv
// Directed bench with a queue-based reference model checked every cycle.
module tb_instruction_assembly_fifo;
  import instruction_assembly_fifo_pkg::*;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] seg_data = '0;
  logic [1:0]  seg_sel = '0;
  logic        seg_we = 1'b0;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;
  logic        clear_err = 1'b0;
  logic        seg_ready, out_valid, empty, full, almost_full;
  logic [79:0] out_instr;
  logic [5:0]  count;
  logic [1:0]  err;

  int checks = 0;
  int errors = 0;

  instruction_assembly_fifo #(.FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_data    (seg_data),
    .seg_sel     (seg_sel),
    .seg_we      (seg_we),
    .seg_ready   (seg_ready),
    .out_instr   (out_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .flush       (flush),
    .clear_err   (clear_err),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  instruction_t q[$];
  logic [31:0]  m_slot[3];
  logic [2:0]   m_valid = '0;
  logic [1:0]   m_err = '0;
  bit           m_c, m_f, m_p, m_pu, m_r;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      q.delete();
      m_valid = '0;
      m_err   = '0;
    end else begin
      m_c  = (m_valid == 3'b111);
      m_f  = (q.size() == DEPTH);
      m_p  = (q.size() != 0) && out_ready;
      m_pu = m_c && (!m_f || m_p);
      m_r  = !(m_c && m_f && !m_p);
      if (clear_err) m_err = 2'b00;
      if (seg_we && !m_r) m_err[0] = 1'b1;
      if (seg_we && seg_sel == 2'd3) m_err[1] = 1'b1;
      if (flush) begin
        q.delete();
        m_valid = '0;
        $display("flush");
      end else begin
        if (m_p) begin
          $display("pop  %h", q[0]);
          void'(q.pop_front());
        end
        if (m_pu) begin
          q.push_back({m_slot[2][15:0], m_slot[1], m_slot[0]});
          m_valid = '0;
          $display("push %h", {m_slot[2][15:0], m_slot[1], m_slot[0]});
        end
        if (seg_we && m_r && seg_sel != 2'd3) begin
          m_slot[int'(seg_sel)]  = seg_data;
          m_valid[int'(seg_sel)] = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("out_valid",   out_valid,   q.size() != 0);
      chk("empty",       empty,       q.size() == 0);
      chk("full",        full,        q.size() == DEPTH);
      chk("almost_full", almost_full, q.size() >= DEPTH - 2);
      chk("count",       count,       q.size());
      chk("out_instr",   out_instr,   (q.size() != 0) ? q[0] : 80'h0);
      chk("err",         err,         m_err);
      chk("seg_ready",   seg_ready,
          !((m_valid == 3'b111) && (q.size() == DEPTH) && !((q.size() != 0) && out_ready)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] s, input logic [31:0] d);
    seg_sel  = s;
    seg_data = d;
    seg_we   = 1'b1;
    tick();
    seg_we   = 1'b0;
  endtask

  task automatic wr_instr(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    wr(2'd0, a);
    wr(2'd1, b);
    wr(2'd2, c);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty", empty, 1'b1);
    chk("rst_seg_ready", seg_ready, 1'b1);
    chk("rst_out_instr", out_instr, 80'h0);
    rst = 1'b1;
    tick();

    // Basic assembly and 2-edge latency.
    wr_instr(32'h11111111, 32'h22222222, 32'h00003333);
    chk("lat_not_yet", out_valid, 1'b0);
    tick();
    chk("lat_valid", out_valid, 1'b1);
    chk("basic_instr", out_instr, 80'h3333_22222222_11111111);
    chk("basic_count", count, 6'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Out-of-order segments with a rewrite.
    wr(2'd2, 32'h00004444);
    wr(2'd0, 32'hAAAAAAAA);
    wr(2'd0, 32'hBBBBBBBB);
    wr(2'd1, 32'h55555555);
    tick();
    chk("rewrite_low", out_instr[31:0], 32'hBBBBBBBB);
    chk("rewrite_instr", out_instr, 80'h4444_55555555_BBBBBBBB);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Fill to full with the decoder stalled.
    for (int i = 0; i < DEPTH; i++) begin
      wr_instr(32'hA0000000 | 32'(i), 32'hB0000000 | 32'(i), 32'h0000C000 | 32'(i));
      if (i == 29) chk("af_at_29", almost_full, 1'b0);
      if (i == 30) chk("af_at_30", almost_full, 1'b1);
    end
    tick();
    chk("fill_full", full, 1'b1);
    chk("fill_count", count, 6'd32);
    wr_instr(32'hD0000000, 32'hD1111111, 32'h0000D222);
    chk("stall_ready", seg_ready, 1'b0);
    wr(2'd1, 32'hDEAD0000);
    chk("overflow_err", err, 2'b01);
    out_ready = 1'b1;
    #1;
    chk("ready_with_pop", seg_ready, 1'b1);
    tick();
    out_ready = 1'b0;
    chk("full_swap_count", count, 6'd32);
    chk("head_after_pop", out_instr, 80'hC001_B0000001_A0000001);

    // Second same-cycle push/pop while full, with errors cleared.
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    chk("clear_err", err, 2'b00);
    wr_instr(32'hE0000000, 32'hE1111111, 32'h0000E222);
    out_ready = 1'b1;
    tick();
    chk("swap2_count", count, 6'd32);
    chk("swap2_err", err, 2'b00);
    repeat (DEPTH) tick();
    out_ready = 1'b0;
    chk("drained", empty, 1'b1);

    // Bad segment select.
    wr(2'd0, 32'h01234567);
    wr(2'd3, 32'hFFFFFFFF);
    chk("bad_sel_err", err, 2'b10);
    wr(2'd1, 32'h89ABCDEF);
    wr(2'd2, 32'h0000FEDC);
    tick();
    chk("bad_sel_instr", out_instr, 80'hFEDC_89ABCDEF_01234567);
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    chk("bad_sel_clear", err, 2'b00);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Flush with entries and a partial staging.
    for (int i = 0; i < 5; i++) wr_instr(32'h50000000 | 32'(i), 32'h60000000, 32'h00007000);
    tick();
    chk("pre_flush_count", count, 6'd5);
    wr(2'd0, 32'h99999999);
    wr(2'd1, 32'h88888888);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_empty", empty, 1'b1);
    chk("flush_count", count, 6'd0);
    wr_instr(32'h12345678, 32'h9ABCDEF0, 32'h00001357);
    tick();
    chk("post_flush_instr", out_instr, 80'h1357_9ABCDEF0_12345678);
    chk("post_flush_count", count, 6'd1);

    // Asynchronous reset mid-assembly.
    wr(2'd3, 32'h0);
    wr(2'd0, 32'h77777777);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_empty", empty, 1'b1);
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_count", count, 6'd0);
    chk("arst_instr", out_instr, 80'h0);
    chk("arst_err", err, 2'b00);
    chk("arst_ready", seg_ready, 1'b1);
    chk("arst_full", {full, almost_full}, 2'b00);
    @(posedge clk);
    #1;
    rst = 1'b1;
    wr(2'd1, 32'h24242424);
    wr(2'd2, 32'h00003636);
    tick();
    chk("partial_lost", out_valid, 1'b0);
    wr(2'd0, 32'h48484848);
    tick();
    chk("after_arst_instr", out_instr, 80'h3636_24242424_48484848);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_assembly_fifo.md
# instruction_assembly_fifo

Parametrised successor to the three-lane instruction buffer. A host writes instruction segments into a staging register, and only complete instructions are pushed into a single circular buffer, so segment lanes can never fall out of alignment. The read side is first-word-fall-through with a valid/ready handshake toward the instruction decoder. The block adds flush, occupancy/almost-full reporting and sticky error flags.

## Interface
- INSTR_WIDTH, 10*BYTE_WIDTH (80): width of one instruction.
- SEG_WIDTH, 4*BYTE_WIDTH (32): width of one host write.
- NUM_SEGS, derived localparam ceil(INSTR_WIDTH/SEG_WIDTH) (3): segments per instruction. The top segment uses only its low INSTR_WIDTH-(NUM_SEGS-1)*SEG_WIDTH bits.
- FIFO_DEPTH, 32: entries; power of two, ≥2.
- ALMOST_FULL_LEVEL, FIFO_DEPTH-2: almost_full asserts when count ≥ this value.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- seg_data  in  SEG_WIDTH  segment payload.
- seg_sel  in  $clog2(NUM_SEGS)  segment index; 0 is least significant.
- seg_we  in  1  segment write strobe.
- seg_ready  out  1  segment write will be accepted this cycle.
- out_instr  out  INSTR_WIDTH  head instruction; all zeros when empty.
- out_valid  out  1  head is valid (equals !empty).
- out_ready  in  1  decoder consumes the head.
- flush  in  1  synchronous clear of the buffer and staging.
- clear_err  in  1  clears err.
- count  out  $clog2(FIFO_DEPTH)+1  occupancy.
- empty, full, almost_full  out  1 each  status.
- err  out  2  sticky error flags. Bit 0 = write rejected (overflow). Bit 1 = seg_sel ≥ NUM_SEGS.

## Operation
- Staging register: NUM_SEGS segment slots, each with a valid bit.
  - An accepted write stores seg_data into slot seg_sel and sets its valid bit.
  - Rewriting an already-valid slot overwrites it; the last write wins.
- Staging is complete when all valid bits are set.
- push = complete && (!full || pop).
  - On push, the assembled instruction is written at wr_ptr and all staging valid bits clear.
- pop = out_valid && out_ready; rd_ptr advances on pop.
- Pointers are $clog2(FIFO_DEPTH)+1 bits wide, with the MSB used as the wrap bit.
  - full when the index bits are equal and the wrap bits differ.
  - empty when the pointers are equal.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- seg_ready = !(complete && full && !pop).
  - seg_we while !seg_ready: the write is dropped, staging is unchanged, err[0] is set.
- seg_we with seg_sel ≥ NUM_SEGS: the write is ignored and err[1] is set.
- Push and an accepted seg_we in the same cycle: slots clear, then the new segment's slot is set.
  - The new segment starts the next instruction.
- out_ready while empty has no effect and raises no error.
- flush has highest priority.
  - Clears pointers, count and staging.
  - Pending push and pop are discarded; the seg_we that cycle is discarded.
  - err is not cleared.
- clear_err clears err. If a new error occurs in the same cycle, the new error wins.
- Reset values:
  - Pointers, count, staging valid bits and err are 0.
  - empty=1, out_valid=0, full=0, almost_full=0, seg_ready=1, out_instr=0.
  - Storage contents are not reset.

## Timing
- The last segment accepted at edge E0 makes complete true after E0. Push occurs at E1 and out_valid rises after E1. Minimum write-to-read latency is 2 edges after the final segment.
- Sustained throughput is one instruction per NUM_SEGS cycles. With NUM_SEGS=1, throughput is one instruction per cycle with zero bubbles.
- The pop takes effect at the edge. The next head is visible combinationally afterwards.
- A simultaneous push and pop when full is allowed; count stays at FIFO_DEPTH.
- A simultaneous push and pop when empty is impossible, since out_valid=0.
- Status outputs and count are registered-state derived: they change only after an edge.
- Asynchronous reset asserted mid-assembly: the partial instruction is lost and all outputs return to reset values immediately.

## Structure
- vTPU_pack additions:
  - SEGMENT_TYPE.
  - INSTR_SEG_COUNT constant.
  - INSTRUCTION_TYPE retained.
  - Error-bit index constants ERR_OVERFLOW=0, ERR_BAD_SEL=1.
- Sub-module instruction_stager: slots, valid bits, complete flag, the assembled word, and the clear-on-push logic.
- The top level holds the circular buffer, pointers, count, handshake and error logic.

## Test plan
- Reset, then write segs 0,1,2 = 0x11111111, 0x22222222, 0x3333 → out_valid after 2 edges; out_instr = 0x3333_22222222_11111111; count=1.
- Write segments in order 2,0,1, with seg 0 written twice (0xAAAA_AAAA then 0xBBBBBBBB) → the head holds 0xBBBBBBBB in the low word.
- Fill 32 instructions with out_ready=0 → full=1, almost_full set from count 30. A 33rd complete staging makes seg_ready=0. A further seg_we sets err[0]. Raising out_ready drains entries in order and the stalled instruction enters the buffer.
- Full buffer with out_ready=1 while staging completes → push and pop in the same cycle, count stays 32, no error.
- seg_sel=3 write → err[1]=1 and staging is unchanged. clear_err → err=0.
- Flush with 5 entries and a partial staging → empty=1, count=0, and the next three segments form a fresh instruction. Asynchronous rst pulse mid-stream → all reset values.
